// File: rtl/servo_pkg.sv
// Shared definitions for the servo PWM drive path: FSM states, default
// timing constants for a 50 MHz clock, and the centre-width helper.
package servo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } servo_state_e;

  localparam int unsigned CLOCK_HZ              = 50_000_000;
  localparam int unsigned DEFAULT_PERIOD_CYCLES = 1_000_000;  // 20 ms
  localparam int unsigned DEFAULT_MIN_PULSE     = 50_000;     // 1 ms
  localparam int unsigned DEFAULT_MAX_PULSE     = 100_000;    // 2 ms

  // Midpoint of the pulse range; summed in 33 bits so it cannot overflow.
  function automatic logic [31:0] center_width(input logic [31:0] lo,
                                               input logic [31:0] hi);
    logic [32:0] sum;
    sum = {1'b0, lo} + {1'b0, hi};
    return 32'(sum >> 1);
  endfunction

endpackage

// File: rtl/servo_cmd_slot.sv
// One-deep command slot: accepts a width over valid/ready, clamps it to the
// safe pulse range and holds it until the PWM core takes it at a boundary.
module servo_cmd_slot
  import servo_pkg::*;
#(
  parameter int unsigned MIN_PULSE = DEFAULT_MIN_PULSE,
  parameter int unsigned MAX_PULSE = DEFAULT_MAX_PULSE
) (
  input  logic        clock_clk,
  input  logic        reset_reset,
  input  logic        cmd_valid,
  input  logic [31:0] cmd_width,
  input  logic        take,
  output logic        cmd_ready,
  output logic [31:0] pending,
  output logic        pending_full,
  output logic        clamped
);

  localparam logic [31:0] CENTER = center_width(MIN_PULSE, MAX_PULSE);

  logic        accept;
  logic [31:0] limited_width;
  logic        out_of_range;

  assign cmd_ready = ~pending_full;
  assign accept    = cmd_valid & cmd_ready;

  // Clamp the requested width into [MIN_PULSE, MAX_PULSE] and flag it.
  always_comb begin
    limited_width = cmd_width;
    out_of_range  = 1'b0;
    if (cmd_width < MIN_PULSE) begin
      limited_width = MIN_PULSE;
      out_of_range  = 1'b1;
    end else if (cmd_width > MAX_PULSE) begin
      limited_width = MAX_PULSE;
      out_of_range  = 1'b1;
    end
  end

  // A take only empties the slot; an accept in the same cycle refills it,
  // since take can only coincide with accept when the slot was already empty.
  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      pending      <= CENTER;
      pending_full <= 1'b0;
      clamped      <= 1'b0;
    end else begin
      if (take) begin
        pending_full <= 1'b0;
      end
      if (accept) begin
        pending      <= limited_width;
        pending_full <= 1'b1;
        clamped      <= out_of_range;
      end
    end
  end

endmodule

// File: rtl/servo_pwm_gen.sv
// Fixed-period servo PWM generator. Commanded widths arrive through the
// command slot, are adopted only at period boundaries and optionally
// slew-limited so the servo never sees a larger jump than MAX_STEP per period.
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES = DEFAULT_PERIOD_CYCLES,
  parameter int unsigned MIN_PULSE     = DEFAULT_MIN_PULSE,
  parameter int unsigned MAX_PULSE     = DEFAULT_MAX_PULSE,
  parameter int unsigned MAX_STEP      = 0
) (
  input  logic        clock_clk,
  input  logic        reset_reset,
  input  logic        enable,
  input  logic        cmd_valid,
  input  logic [31:0] cmd_width,
  output logic        cmd_ready,
  output logic        pwm_out,
  output logic        period_start,
  output logic [31:0] active_width,
  output logic        clamped
);

  localparam logic [31:0] CENTER     = center_width(MIN_PULSE, MAX_PULSE);
  localparam logic [31:0] LAST_COUNT = PERIOD_CYCLES - 1;
  localparam logic [31:0] STEP       = MAX_STEP;

  servo_state_e state;
  logic [31:0]  counter;
  logic [31:0]  target;
  logic [31:0]  target_new;
  logic [31:0]  pending;
  logic         pending_full;
  logic         boundary;

  // Move a toward t by at most STEP; STEP of zero means jump straight there.
  function automatic logic [31:0] step_width(input logic [31:0] a,
                                             input logic [31:0] t);
    logic [31:0] diff;
    diff = (t > a) ? (t - a) : (a - t);
    if (STEP == 32'd0 || diff <= STEP) return t;
    else if (t > a) return a + STEP;
    else return a - STEP;
  endfunction

  servo_cmd_slot #(
    .MIN_PULSE (MIN_PULSE),
    .MAX_PULSE (MAX_PULSE)
  ) u_slot (
    .clock_clk    (clock_clk),
    .reset_reset  (reset_reset),
    .cmd_valid    (cmd_valid),
    .cmd_width    (cmd_width),
    .take         (boundary & pending_full),
    .cmd_ready    (cmd_ready),
    .pending      (pending),
    .pending_full (pending_full),
    .clamped      (clamped)
  );

  assign boundary = enable &&
                    ((state == IDLE) || (state == LOW && counter == LAST_COUNT));
  assign target_new = pending_full ? pending : target;

  // Period FSM with registered outputs; width updates happen only on boundaries.
  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state        <= IDLE;
      counter      <= 32'd0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
      active_width <= CENTER;
      target       <= CENTER;
    end else begin
      period_start <= 1'b0;
      case (state)
        IDLE: begin
          counter <= 32'd0;
          pwm_out <= 1'b0;
          if (enable) begin
            state        <= HIGH;
            pwm_out      <= 1'b1;
            period_start <= 1'b1;
          end
        end
        HIGH: begin
          counter <= counter + 32'd1;
          if (counter == active_width - 32'd1) begin
            state   <= LOW;
            pwm_out <= 1'b0;
          end
        end
        LOW: begin
          if (counter == LAST_COUNT) begin
            counter <= 32'd0;
            if (enable) begin
              state        <= HIGH;
              pwm_out      <= 1'b1;
              period_start <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            counter <= counter + 32'd1;
          end
        end
        default: begin
          state   <= IDLE;
          counter <= 32'd0;
          pwm_out <= 1'b0;
        end
      endcase
      if (boundary) begin
        target       <= target_new;
        active_width <= step_width(active_width, target_new);
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Directed bench for servo_pwm_gen with a 100-cycle period and a 10..20 range.
// A second instance with MAX_STEP = 3 shares the stimulus for the slew checks.
module tb_servo_pwm_gen;

  logic        clock_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic        enable = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [31:0] cmd_width = 32'd0;

  logic        cmd_ready, pwm_out, period_start, clamped;
  logic [31:0] active_width;
  logic        s_cmd_ready, s_pwm_out, s_period_start, s_clamped;
  logic [31:0] s_active_width;

  int total = 0;
  int bad = 0;

  servo_pwm_gen #(
    .PERIOD_CYCLES (100), .MIN_PULSE (10), .MAX_PULSE (20), .MAX_STEP (0)
  ) dut (
    .clock_clk (clock_clk), .reset_reset (reset_reset), .enable (enable),
    .cmd_valid (cmd_valid), .cmd_width (cmd_width), .cmd_ready (cmd_ready),
    .pwm_out (pwm_out), .period_start (period_start),
    .active_width (active_width), .clamped (clamped)
  );

  servo_pwm_gen #(
    .PERIOD_CYCLES (100), .MIN_PULSE (10), .MAX_PULSE (20), .MAX_STEP (3)
  ) dut_s (
    .clock_clk (clock_clk), .reset_reset (reset_reset), .enable (enable),
    .cmd_valid (cmd_valid), .cmd_width (cmd_width), .cmd_ready (s_cmd_ready),
    .pwm_out (s_pwm_out), .period_start (s_period_start),
    .active_width (s_active_width), .clamped (s_clamped)
  );

  always #5 clock_clk = ~clock_clk;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] expected);
    total++;
    if (got !== expected) begin
      bad++;
      $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic valid,
                               input logic [31:0] width);
    enable    = en;
    cmd_valid = valid;
    cmd_width = width;
  endtask

  task automatic skip(input int n);
    for (int i = 0; i < n; i++) @(negedge clock_clk);
  endtask

  // Advance to the next negedge on which period_start is seen, bounded.
  task automatic wait_for_start();
    int n;
    n = 0;
    do begin
      @(negedge clock_clk);
      n++;
    end while (!period_start && n < 300);
    if (!period_start) checkOutput("start_timeout", 32'd0, 32'd1);
  endtask

  // Present one command for a single cycle (slot assumed empty).
  task automatic send_cmd(input logic [31:0] width);
    applyStimulus(enable, 1'b1, width);
    @(negedge clock_clk);
    applyStimulus(enable, 1'b0, 32'd0);
  endtask

  initial begin
    int high_cnt;
    int per_cnt;

    $display("[TB] start");
    skip(3);
    checkOutput("rst_pwm", {31'd0, pwm_out}, 32'd0);
    checkOutput("rst_ps", {31'd0, period_start}, 32'd0);
    checkOutput("rst_aw", active_width, 32'd15);
    checkOutput("rst_ready", {31'd0, cmd_ready}, 32'd1);
    reset_reset = 1'b0;
    skip(2);
    checkOutput("idle_pwm", {31'd0, pwm_out}, 32'd0);

    // Free-running at the centre width.
    applyStimulus(1'b1, 1'b0, 32'd0);
    @(negedge clock_clk);
    checkOutput("first_ps", {31'd0, period_start}, 32'd1);
    checkOutput("first_pwm", {31'd0, pwm_out}, 32'd1);
    checkOutput("center_aw", active_width, 32'd15);
    for (int p = 0; p < 2; p++) begin
      high_cnt = 0;
      per_cnt = 0;
      do begin
        if (pwm_out) high_cnt++;
        per_cnt++;
        @(negedge clock_clk);
      end while (!period_start && per_cnt < 300);
      checkOutput("high_time", high_cnt, 32'd15);
      checkOutput("period_len", per_cnt, 32'd100);
    end

    // Clamping of low, high and in-range commands.
    send_cmd(32'd5);
    checkOutput("clamp_lo_flag", {31'd0, clamped}, 32'd1);
    wait_for_start();
    checkOutput("clamp_lo_aw", active_width, 32'd10);
    send_cmd(32'd30);
    checkOutput("clamp_hi_flag", {31'd0, clamped}, 32'd1);
    wait_for_start();
    checkOutput("clamp_hi_aw", active_width, 32'd20);
    send_cmd(32'd12);
    checkOutput("inrange_flag", {31'd0, clamped}, 32'd0);
    wait_for_start();
    checkOutput("inrange_aw", active_width, 32'd12);

    // Accept on the boundary edge, then back-pressure a second command.
    skip(99);
    applyStimulus(1'b1, 1'b1, 32'd17);
    @(negedge clock_clk);
    checkOutput("bnd_ps", {31'd0, period_start}, 32'd1);
    checkOutput("bnd_ready", {31'd0, cmd_ready}, 32'd0);
    checkOutput("bnd_aw_old", active_width, 32'd12);
    applyStimulus(1'b1, 1'b1, 32'd18);
    skip(50);
    checkOutput("bp_ready_mid", {31'd0, cmd_ready}, 32'd0);
    checkOutput("bp_aw_stable", active_width, 32'd12);
    skip(49);
    checkOutput("bp_ready_end", {31'd0, cmd_ready}, 32'd0);
    @(negedge clock_clk);
    checkOutput("bp_ps", {31'd0, period_start}, 32'd1);
    checkOutput("bp_aw_first", active_width, 32'd17);
    checkOutput("bp_ready_free", {31'd0, cmd_ready}, 32'd1);
    @(negedge clock_clk);
    checkOutput("bp_second_acc", {31'd0, cmd_ready}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0);
    wait_for_start();
    checkOutput("bp_aw_second", active_width, 32'd18);

    // Drop enable mid-pulse: period completes, then idle.
    high_cnt = 0;
    per_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (pwm_out) high_cnt++;
      if (i > 0 && period_start) per_cnt++;
      if (i == 5) applyStimulus(1'b0, 1'b0, 32'd0);
      @(negedge clock_clk);
    end
    checkOutput("dis_high", high_cnt, 32'd18);
    checkOutput("dis_extra_ps", per_cnt, 32'd0);
    checkOutput("dis_ps", {31'd0, period_start}, 32'd0);
    skip(20);
    checkOutput("dis_pwm", {31'd0, pwm_out}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0);
    @(negedge clock_clk);
    checkOutput("reen_ps", {31'd0, period_start}, 32'd1);
    checkOutput("reen_pwm", {31'd0, pwm_out}, 32'd1);

    // Asynchronous reset in the middle of a high pulse with the slot full.
    send_cmd(32'd11);
    checkOutput("pre_rst_ready", {31'd0, cmd_ready}, 32'd0);
    skip(2);
    checkOutput("pre_rst_pwm", {31'd0, pwm_out}, 32'd1);
    #2 reset_reset = 1'b1;
    #1;
    checkOutput("async_pwm", {31'd0, pwm_out}, 32'd0);
    checkOutput("async_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("async_aw", active_width, 32'd15);
    applyStimulus(1'b0, 1'b1, 32'd20);
    skip(2);
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("rst_ignore_valid", {31'd0, cmd_ready}, 32'd1);
    reset_reset = 1'b0;
    @(negedge clock_clk);
    checkOutput("post_rst_aw", active_width, 32'd15);
    checkOutput("post_rst_clamped", {31'd0, clamped}, 32'd0);

    // Slew-limited instance: 15 -> 20 and then 20 -> 10 in steps of 3.
    applyStimulus(1'b1, 1'b0, 32'd0);
    @(negedge clock_clk);
    checkOutput("slew_ps", {31'd0, s_period_start}, 32'd1);
    checkOutput("slew_pwm", {31'd0, s_pwm_out}, 32'd1);
    send_cmd(32'd20);
    checkOutput("slew_ready", {31'd0, s_cmd_ready}, 32'd0);
    checkOutput("slew_clamped", {31'd0, s_clamped}, 32'd0);
    wait_for_start();
    checkOutput("slew_up1", s_active_width, 32'd18);
    checkOutput("noslew_up", active_width, 32'd20);
    wait_for_start();
    checkOutput("slew_up2", s_active_width, 32'd20);
    send_cmd(32'd10);
    wait_for_start();
    checkOutput("slew_dn1", s_active_width, 32'd17);
    wait_for_start();
    checkOutput("slew_dn2", s_active_width, 32'd14);
    wait_for_start();
    checkOutput("slew_dn3", s_active_width, 32'd11);
    wait_for_start();
    checkOutput("slew_dn4", s_active_width, 32'd10);
    wait_for_start();
    checkOutput("slew_hold", s_active_width, 32'd10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
